alu_exec_unit: RTL and testbench

Execute-stage ALU for the RISC-V pipeline. Consumes the 4-bit `Operation` code produced by the ALU controller plus two operands, and returns a registered result through a valid/ready handshake. Shifts run on an iterative one-bit-per-cycle shifter, so the pipeline must stall on `in_ready`. The unit holds one in-flight operation and one output register, and supports a pipeline flush.

---
 rtl/alu_exec_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU for the RISC-V pipeline. Takes the 4-bit Operation code
// from the ALU controller plus two operands. It returns a registered result
// through a valid/ready handshake.
//
// Shifts use an iterative one-bit-per-cycle shifter. A shift by k > 0 keeps
// in_ready low for k cycles. The unit holds one in-flight operation and one
// output register.
//
// Build option:
//   ALU_FAST_SHIFT_EN  When defined, SLL/SRL/SRA use a single-cycle barrel
//                      shifter and every operation has latency 1. The SHIFT
//                      state, counter and work register are not built.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   flush      in   squashes any in-flight or held operation
//   in_valid   in   operation presented
//   in_ready   out  unit can accept an operation this cycle
//   Operation  in   [3:0] op code (1 ADD .. 12 BGE; 0 and 13-15 give 0)
//   SrcA       in   [DATA_W-1:0] operand A
//   SrcB       in   [DATA_W-1:0] operand B (shift amount is SrcB[4:0])
//   out_valid  out  ALUResult is valid
//   out_ready  in   consumer takes the result this cycle
//   ALUResult  out  [DATA_W-1:0] registered result
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_BEQ = 4'd9;
    localparam logic [3:0] OP_BNE = 4'd10;
    localparam logic [3:0] OP_SLT = 4'd11;
    localparam logic [3:0] OP_BGE = 4'd12;

    // Compare ops return the condition in bit 0, with zeros above it.
    function automatic logic [DATA_W-1:0] flag(input logic cond);
        return {{(DATA_W-1){1'b0}}, cond};
    endfunction

    // Single-cycle result. In the iterative build this function only sees
    // shifts when the shift amount is 0, so for those it passes SrcA through.
    function automatic logic [DATA_W-1:0] alu_result(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: r = a << b[4:0];
            OP_SRL: r = a >> b[4:0];
            OP_SRA: r = $signed(a) >>> b[4:0];
`else
            OP_SLL: r = a;
            OP_SRL: r = a;
            OP_SRA: r = a;
`endif
            OP_BEQ: r = flag(a == b);
            OP_BNE: r = flag(a != b);
            OP_SLT: r = flag($signed(a) <  $signed(b));
            OP_BGE: r = flag($signed(a) >= $signed(b));
            default: r = '0;
        endcase
        return r;
    endfunction

    logic              accept;
    logic              out_valid_d;
    logic [DATA_W-1:0] result_d;

    assign accept = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN

    // Every op completes in one cycle. Only the output register holds state.
    assign in_ready = reset && !flush && (!out_valid || out_ready);

    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_valid_d = out_valid && !out_ready;
        result_d    = ALUResult;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            result_d    = alu_result(Operation, SrcA, SrcB);
            out_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        // NOTE: ALUResult is a datapath register, but it is still reset,
        // because a reset must leave a defined 0 on the result port.
        if (!reset) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
        end else begin
            out_valid <= out_valid_d;
            ALUResult <= result_d;
        end
    end

`else

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    typedef enum logic [1:0] {
        SK_SLL,
        SK_SRL,
        SK_SRA
    } shift_e;

    function automatic shift_e shift_kind(input logic [3:0] op);
        case (op)
            OP_SLL:  return SK_SLL;
            OP_SRL:  return SK_SRL;
            default: return SK_SRA;
        endcase
    endfunction

    state_e            state_q, state_d;
    shift_e            kind_q, kind_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0] work_shifted;
    logic [4:0]        shamt;
    logic              is_shift;

    assign shamt    = SrcB[4:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                      (Operation == OP_SRA);

    // One bit of shift per cycle. SRA copies the sign bit into the MSB.
    always_comb begin
        case (kind_q)
            SK_SLL:  work_shifted = {work_q[DATA_W-2:0], 1'b0};
            SK_SRL:  work_shifted = {1'b0, work_q[DATA_W-1:1]};
            default: work_shifted = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
        endcase
    end

    // Acceptance also needs the output slot to be free or draining. Because
    // of this, a shift that completes later can never overwrite a held result.
    assign in_ready = (state_q == ST_IDLE) && reset && !flush &&
                      (!out_valid || out_ready);

    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_valid_d = out_valid && !out_ready;
        result_d    = ALUResult;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            work_d  = SrcA;
                            cnt_d   = shamt;
                            kind_d  = shift_kind(Operation);
                            state_d = ST_SHIFT;
                        end else begin
                            result_d    = alu_result(Operation, SrcA, SrcB);
                            out_valid_d = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_d = work_shifted;
                    cnt_d  = cnt_q - 5'd1;
                    // Counter at 1 means this cycle applies the last bit.
                    if (cnt_q == 5'd1) begin
                        result_d    = work_shifted;
                        out_valid_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        // NOTE: the work register and result are datapath registers, but they
        // are still reset. An abandoned shift must leave nothing behind, and
        // the result port must show a defined 0.
        if (!reset) begin
            state_q   <= ST_IDLE;
            kind_q    <= SK_SLL;
            cnt_q     <= 5'd0;
            work_q    <= '0;
            out_valid <= 1'b0;
            ALUResult <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            out_valid <= out_valid_d;
            ALUResult <= result_d;
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          k;      // extra cycles of an iterative shift
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the result follows the op-code rules with plain
    // operators. The shift amount is the low five bits of B.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a ^ b;
            4'd4:    return a | b;
            4'd5:    return a & b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return $signed(a) >>> sh;
            4'd9:    return (a == b) ? 32'd1 : 32'd0;
            4'd10:   return (a != b) ? 32'd1 : 32'd0;
            4'd11:   return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input int k);
`ifdef ALU_FAST_SHIFT_EN
        return 1 + 0 * k;
`else
        return 1 + k;
`endif
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op >= 4'd6 && op <= 4'd8) return lat_of(int'(b % 32));
        return lat_of(0);
    endfunction

    // Present an op, wait (bounded) for in_ready, and let it be accepted on
    // the next edge. On return we are 1 time unit into cycle N+1.
    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int n;
        n = 0;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("send_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid. The consumer is ready, so the result is
    // taken on the next edge.
    task automatic wait_result(output logic [31:0] d, output int lat);
        out_ready = 1'b1;
        lat = 1;
        while (!out_valid && lat < 64) begin
            step();
            lat++;
        end
        check("result_valid", {31'b0, out_valid}, 32'd1);
        d = ALUResult;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
    endtask

    logic [31:0] d;
    logic [31:0] ra, rb, rexp;
    logic [3:0]  rop;
    int          lat, hold, gap, seen;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Operation = 4'd0; SrcA = '0; SrcB = '0;

        vecs.push_back('{name:"add",     op:4'd1,  a:32'd5,        b:32'd7,  exp:32'd12,        k:0});
        vecs.push_back('{name:"sub",     op:4'd2,  a:32'd3,        b:32'd5,  exp:32'hFFFFFFFE,  k:0});
        vecs.push_back('{name:"addwrap", op:4'd1,  a:32'hFFFFFFFF, b:32'd1,  exp:32'd0,         k:0});
        vecs.push_back('{name:"xor",     op:4'd3,  a:32'hFF,       b:32'h0F, exp:32'hF0,        k:0});
        vecs.push_back('{name:"or",      op:4'd4,  a:32'hF0F0,     b:32'h0F0F, exp:32'hFFFF,    k:0});
        vecs.push_back('{name:"and",     op:4'd5,  a:32'hF0F0,     b:32'hFF00, exp:32'hF000,    k:0});
        vecs.push_back('{name:"bge",     op:4'd12, a:32'hFFFFFFFF, b:32'd1,  exp:32'd0,         k:0});
        vecs.push_back('{name:"blt",     op:4'd11, a:32'hFFFFFFFF, b:32'd1,  exp:32'd1,         k:0});
        vecs.push_back('{name:"beq",     op:4'd9,  a:32'd7,        b:32'd7,  exp:32'd1,         k:0});
        vecs.push_back('{name:"bne",     op:4'd10, a:32'd7,        b:32'd7,  exp:32'd0,         k:0});
        vecs.push_back('{name:"code14",  op:4'd14, a:32'd9,        b:32'd3,  exp:32'd0,         k:0});
        vecs.push_back('{name:"code0",   op:4'd0,  a:32'd9,        b:32'd3,  exp:32'd0,         k:0});
        vecs.push_back('{name:"sll0",    op:4'd6,  a:32'd1,        b:32'h20, exp:32'd1,         k:0});
        vecs.push_back('{name:"sll3",    op:4'd6,  a:32'd1,        b:32'd3,  exp:32'd8,         k:3});
        vecs.push_back('{name:"sra4",    op:4'd8,  a:32'h80000000, b:32'd4,  exp:32'hF8000000,  k:4});
        vecs.push_back('{name:"srl31",   op:4'd7,  a:32'h80000000, b:32'd31, exp:32'd1,         k:31});
        vecs.push_back('{name:"sra31",   op:4'd8,  a:32'h80000000, b:32'd31, exp:32'hFFFFFFFF,  k:31});

        // Reset state
        repeat (2) step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_release_ready", {31'b0, in_ready}, 32'd1);
        step();

        // Table-driven vectors
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(d, lat);
            check({"vec_", vecs[i].name}, d, vecs[i].exp);
            check({"lat_", vecs[i].name}, 32'(lat), 32'(lat_of(vecs[i].k)));
        end
        drain();

        // ADD then SUB back to back
        send(4'd1, 32'd5, 32'd7);
        check("b2b_add_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_add_val", ALUResult, 32'd12);
        send(4'd2, 32'd3, 32'd5);
        check("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_sub_val", ALUResult, 32'hFFFFFFFE);
        step();
        check("b2b_drained", {31'b0, out_valid}, 32'd0);

        // SRA latency and in_ready stall
        send(4'd8, 32'h80000000, 32'd4);
`ifndef ALU_FAST_SHIFT_EN
        for (int c = 1; c <= 4; c++) begin
            check("sra_stall_ready", {31'b0, in_ready}, 32'd0);
            check("sra_stall_valid", {31'b0, out_valid}, 32'd0);
            step();
        end
`endif
        check("sra_valid", {31'b0, out_valid}, 32'd1);
        check("sra_val", ALUResult, 32'hF8000000);
        drain();

        // Backpressure. A new op waits and is accepted in the handshake cycle.
        out_ready = 1'b0;
        send(4'd3, 32'hFF, 32'h0F);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_val", ALUResult, 32'hF0);
        Operation = 4'd1; SrcA = 32'd1; SrcB = 32'd2; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_val", ALUResult, 32'hF0);
            check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        check("bp_next_val", ALUResult, 32'd3);
        drain();

        // A flush with in_valid drops the op
        flush = 1'b1;
        Operation = 4'd1; SrcA = 32'd100; SrcB = 32'd1; in_valid = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drop_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("flush_drop_valid2", {31'b0, out_valid}, 32'd0);

        // A flush squashes a held result; ALUResult keeps its value
        out_ready = 1'b0;
        send(4'd5, 32'hF0F0, 32'hFF00);
        check("flush_held_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_held_cleared", {31'b0, out_valid}, 32'd0);
        check("flush_held_keep", ALUResult, 32'hF000);
        drain();

`ifndef ALU_FAST_SHIFT_EN
        // A flush in cycle 5 of an SLL of 1 by 20 abandons the shift
        send(4'd1, 32'd5, 32'd7);
        wait_result(d, lat);
        send(4'd6, 32'd1, 32'd20);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_shift_ready", {31'b0, in_ready}, 32'd1);
        check("flush_shift_keep", ALUResult, 32'd12);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("flush_shift_no_valid", 32'(seen), 32'd0);
`endif

        // Reset in the middle of a shift (or with a held result in the fast build)
        send(4'd3, 32'hFF, 32'h0F);
        wait_result(d, lat);
`ifndef ALU_FAST_SHIFT_EN
        send(4'd7, 32'hFFFF0000, 32'd10);
        repeat (3) step();
`else
        out_ready = 1'b0;
`endif
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("midrst_no_valid", 32'(seen), 32'd0);

        // Randomized ops against the reference model, with random gaps
        // and random consumer stalls
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h7;
            rexp = ref_alu(rop, ra, rb);
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            send(rop, ra, rb);
            wait_result(d, lat);
            check("rnd_val", d, rexp);
            check("rnd_lat", 32'(lat), 32'(ref_lat(rop, rb)));
            hold = $urandom_range(0, 2);
            if (hold > 0) begin
                out_ready = 1'b0;
                repeat (hold) begin
                    step();
                    check("rnd_hold_valid", {31'b0, out_valid}, 32'd1);
                    check("rnd_hold_val", ALUResult, rexp);
                end
                out_ready = 1'b1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
